// File: rtl/enc8b10b_ctrl.sv
// 8b/10b encoder with post-reset K28.5 comma sync and a one-deep valid/ready output register.
// out_code is {a,b,c,d,e,i,f,g,h,j}; running disparity is carried in r_rd.
module enc8b10b_ctrl #(
  parameter int unsigned N_SYNC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_k,
  output logic       in_ready,
  output logic       out_valid,
  output logic [9:0] out_code,
  input  logic       out_ready,
  output logic       rd_out,
  output logic       sync_done,
  output logic       err_k
);
  localparam logic [7:0] L_SYNC_CNT = 8'(N_SYNC);
  localparam logic [7:0] L_K28_5    = 8'hBC;

  typedef enum logic {ST_SYNC = 1'b0, ST_DATA = 1'b1} state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic       r_out_valid, r_rd, r_err_k;
  logic [9:0] r_out_code;

  logic       w_load, w_accept, w_k_legal;
  logic [7:0] w_sym;
  logic       w_sym_k, w_err;
  logic [4:0] w_x;
  logic [2:0] w_y;
  logic [5:0] w_6b_neg, w_6b;
  logic [3:0] w_4b_neg, w_4b;
  logic       w_6b_flip, w_4b_flip, w_rd_mid, w_rd_next, w_alt7;

  assign w_load = !r_out_valid || out_ready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    in_ready     = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_load) begin
          w_cnt_next = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_state_next = ST_DATA;
        end
      end
      ST_DATA: in_ready = w_load;
      default: w_state_next = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SYNC;
      r_cnt   <= L_SYNC_CNT;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_accept  = in_ready && in_valid;
  assign w_k_legal = (in_data[4:0] == 5'd28) ||
                     ((in_data[7:5] == 3'd7) && ((in_data[4:0] == 5'd23) || (in_data[4:0] == 5'd27) ||
                                                 (in_data[4:0] == 5'd29) || (in_data[4:0] == 5'd30)));

  // Idle, sync and illegal-K all fall back to K28.5.
  always_comb begin
    w_sym   = L_K28_5;
    w_sym_k = 1'b1;
    w_err   = 1'b0;
    if (w_accept) begin
      if (in_k && !w_k_legal) begin
        w_err = 1'b1;
      end else begin
        w_sym   = in_data;
        w_sym_k = in_k;
      end
    end
  end

  assign w_x = w_sym[4:0];
  assign w_y = w_sym[7:5];

  always_comb begin
    w_6b_neg = 6'b000000;
    case (w_x)
      5'd0:  w_6b_neg = 6'b100111;  5'd1:  w_6b_neg = 6'b011101;
      5'd2:  w_6b_neg = 6'b101101;  5'd3:  w_6b_neg = 6'b110001;
      5'd4:  w_6b_neg = 6'b110101;  5'd5:  w_6b_neg = 6'b101001;
      5'd6:  w_6b_neg = 6'b011001;  5'd7:  w_6b_neg = 6'b111000;
      5'd8:  w_6b_neg = 6'b111001;  5'd9:  w_6b_neg = 6'b100101;
      5'd10: w_6b_neg = 6'b010101;  5'd11: w_6b_neg = 6'b110100;
      5'd12: w_6b_neg = 6'b001101;  5'd13: w_6b_neg = 6'b101100;
      5'd14: w_6b_neg = 6'b011100;  5'd15: w_6b_neg = 6'b010111;
      5'd16: w_6b_neg = 6'b011011;  5'd17: w_6b_neg = 6'b100011;
      5'd18: w_6b_neg = 6'b010011;  5'd19: w_6b_neg = 6'b110010;
      5'd20: w_6b_neg = 6'b001011;  5'd21: w_6b_neg = 6'b101010;
      5'd22: w_6b_neg = 6'b011010;  5'd23: w_6b_neg = 6'b111010;
      5'd24: w_6b_neg = 6'b110011;  5'd25: w_6b_neg = 6'b100110;
      5'd26: w_6b_neg = 6'b010110;  5'd27: w_6b_neg = 6'b110110;
      5'd28: w_6b_neg = 6'b001110;  5'd29: w_6b_neg = 6'b101110;
      5'd30: w_6b_neg = 6'b011110;  5'd31: w_6b_neg = 6'b101011;
      default: w_6b_neg = 6'b000000;
    endcase
    if (w_sym_k && (w_x == 5'd28)) w_6b_neg = 6'b001111;
  end

  // The RD+ column is the complement of RD- for unbalanced codes and for D.7 (111000/000111).
  assign w_6b_flip = ($countones(w_6b_neg) != 3) || (w_x == 5'd7);
  assign w_6b      = (r_rd && w_6b_flip) ? ~w_6b_neg : w_6b_neg;
  assign w_rd_mid  = ($countones(w_6b) == 3) ? r_rd : !r_rd;

  assign w_alt7 = w_rd_mid ? ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))
                           : ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20));

  always_comb begin
    w_4b_neg  = 4'b0000;
    w_4b_flip = 1'b1;
    if (w_sym_k) begin
      case (w_y)
        3'd0: w_4b_neg = 4'b1011;  3'd1: w_4b_neg = 4'b0110;
        3'd2: w_4b_neg = 4'b1010;  3'd3: w_4b_neg = 4'b1100;
        3'd4: w_4b_neg = 4'b1101;  3'd5: w_4b_neg = 4'b0101;
        3'd6: w_4b_neg = 4'b1001;  3'd7: w_4b_neg = 4'b0111;
        default: w_4b_neg = 4'b0000;
      endcase
    end else begin
      case (w_y)
        3'd0: w_4b_neg = 4'b1011;
        3'd1: begin w_4b_neg = 4'b1001; w_4b_flip = 1'b0; end
        3'd2: begin w_4b_neg = 4'b0101; w_4b_flip = 1'b0; end
        3'd3: w_4b_neg = 4'b1100;
        3'd4: w_4b_neg = 4'b1101;
        3'd5: begin w_4b_neg = 4'b1010; w_4b_flip = 1'b0; end
        3'd6: begin w_4b_neg = 4'b0110; w_4b_flip = 1'b0; end
        3'd7: w_4b_neg = w_alt7 ? 4'b0111 : 4'b1110;
        default: w_4b_neg = 4'b0000;
      endcase
    end
  end

  assign w_4b      = (w_rd_mid && w_4b_flip) ? ~w_4b_neg : w_4b_neg;
  assign w_rd_next = ($countones(w_4b) == 2) ? w_rd_mid : !w_rd_mid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_code  <= 10'b0;
      r_rd        <= 1'b0;
      r_err_k     <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_code  <= {w_6b, w_4b};
      r_rd        <= w_rd_next;
      r_err_k     <= w_err;
    end
  end

  assign out_valid = r_out_valid;
  assign out_code  = r_out_code;
  assign rd_out    = r_rd;
  assign err_k     = r_err_k;
  assign sync_done = (r_state == ST_DATA);
endmodule

// File: tb/tb_enc8b10b_ctrl.sv
// Self-checking bench for enc8b10b_ctrl: directed vector table, hand sequences and a
// randomized run against a table-based 8b/10b reference model.
module tb_enc8b10b_ctrl;
  localparam int N_SYNC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_k = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, rd_out, sync_done, err_k;
  logic [9:0] out_code;

  enc8b10b_ctrl #(.N_SYNC(N_SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_k(in_k),
    .in_ready(in_ready), .out_valid(out_valid), .out_code(out_code), .out_ready(out_ready),
    .rd_out(rd_out), .sync_done(sync_done), .err_k(err_k)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] T6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] TKN [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [3:0] TKP [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [7:0] LEGAL_K [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                          8'hF7, 8'hFB, 8'hFD, 8'hFE};

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic       m_valid;
  logic [9:0] m_code;
  logic       m_rd;
  logic       m_err;
  int         m_left;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       k;
    logic [9:0] code;
    logic       rd;
    logic       err;
  } vec_t;
  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int ones(input logic [5:0] v);
    int n = 0;
    for (int i = 0; i < 6; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic k_legal(input logic [7:0] b);
    logic ok = 1'b0;
    for (int i = 0; i < 12; i++) if (LEGAL_K[i] == b) ok = 1'b1;
    if (b[4:0] == 5'd28) ok = 1'b1;
    return ok;
  endfunction

  function automatic void enc(input logic [7:0] b, input logic k, input logic rd,
                              output logic [9:0] code, output logic rd_o);
    int x = int'(b[4:0]);
    int y = int'(b[7:5]);
    logic [5:0] s6;
    logic [3:0] s4;
    logic rd_mid, alt;
    if (k && x == 28) s6 = rd ? 6'b110000 : 6'b001111;
    else              s6 = rd ? T6P[x] : T6N[x];
    rd_mid = (2 * ones(s6) - 6 != 0) ? ~rd : rd;
    if (k) begin
      s4 = rd_mid ? TKP[y] : TKN[y];
    end else if (y == 7) begin
      alt = (!rd_mid && (x == 17 || x == 18 || x == 20)) || (rd_mid && (x == 11 || x == 13 || x == 14));
      if (alt) s4 = rd_mid ? 4'b1000 : 4'b0111;
      else     s4 = rd_mid ? 4'b0001 : 4'b1110;
    end else begin
      s4 = rd_mid ? T4P[y] : T4N[y];
    end
    rd_o = (2 * ones({2'b00, s4}) - 4 != 0) ? ~rd_mid : rd_mid;
    code = {s6, s4};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_code  = 10'b0;
    m_rd    = 1'b0;
    m_err   = 1'b0;
    m_left  = N_SYNC;
  endtask

  // Called at posedge+1; applies inputs, checks handshake before the edge and outputs after it.
  task automatic cycle(input logic v, input logic [7:0] d, input logic k, input logic ordy);
    logic ld;
    logic [9:0] c;
    logic r;
    in_valid = v; in_data = d; in_k = k; out_ready = ordy;
    @(negedge clk);
    ld = !m_valid || ordy;
    chk("in_ready", in_ready, (m_left == 0) && ld);
    chk("sync_done", sync_done, m_left == 0);
    if (ld) begin
      m_err = 1'b0;
      if (m_left > 0) begin
        enc(8'hBC, 1'b1, m_rd, c, r);
        m_left--;
      end else if (v && !(k && !k_legal(d))) begin
        enc(d, k, m_rd, c, r);
      end else begin
        enc(8'hBC, 1'b1, m_rd, c, r);
        m_err = v && k;
      end
      m_code = c; m_rd = r; m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_code", out_code, m_code);
    chk("rd_out", rd_out, m_rd);
    chk("err_k", err_k, m_err);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_code"}, out_code, 10'b0);
    chk({tag, "_rd_out"}, rd_out, 1'b0);
    chk({tag, "_err_k"}, err_k, 1'b0);
    chk({tag, "_sync_done"}, sync_done, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
  endtask

  initial begin
    logic [9:0] commas [4];
    logic       v, k, o;
    logic [7:0] d;
    commas[0] = 10'b0011111010; commas[1] = 10'b1100000101;
    commas[2] = 10'b0011111010; commas[3] = 10'b1100000101;

    vecs[0]  = '{1'b1, 8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'hF1, 1'b0, 10'b1000110111, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'h00, 1'b1, 10'b1100000101, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h55, 1'b0, 10'b1100000101, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h03, 1'b0, 10'b1100011011, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'hE7, 1'b0, 10'b0001110001, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'hEB, 1'b0, 10'b1101001110, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'hF7, 1'b1, 10'b1110101000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'hFC, 1'b1, 10'b0011111000, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h60, 1'b0, 10'b1001110011, 1'b1, 1'b0};

    // Power-on reset and comma sync
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_cleared("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N_SYNC; i++) begin
      cycle(1'b1, 8'h00, 1'b0, 1'b1);
      chk($sformatf("sync%0d_code", i), out_code, commas[i]);
      chk($sformatf("sync%0d_done", i), sync_done, i == N_SYNC - 1);
    end
    chk("sync_in_ready", in_ready, 1'b1);

    // Directed back-to-back vectors
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].k, 1'b1);
      chk($sformatf("vec%0d_code", i), out_code, vecs[i].code);
      chk($sformatf("vec%0d_rd", i), rd_out, vecs[i].rd);
      chk($sformatf("vec%0d_err", i), err_k, vecs[i].err);
      $display("vec %0d: data=%02h k=%0d code=%b rd=%0d err=%0d", i, vecs[i].d, vecs[i].k, out_code, rd_out, err_k);
    end

    // Backpressure: five stalled cycles, then the pending D0.0 at RD+
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h00, 1'b0, 1'b0);
      chk($sformatf("stall%0d_code", i), out_code, vecs[12].code);
      chk($sformatf("stall%0d_rd", i), rd_out, vecs[12].rd);
    end
    cycle(1'b1, 8'h00, 1'b0, 1'b1);
    chk("unstall_code", out_code, 10'b0110001011);
    chk("unstall_rd", rd_out, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      k = ($urandom_range(0, 9) == 0);
      d = 8'($urandom);
      if (k && $urandom_range(0, 1) == 1) d = LEGAL_K[$urandom_range(0, 11)];
      o = ($urandom_range(0, 3) != 0);
      cycle(v, d, k, o);
    end

    // Reset mid-stream
    cycle(1'b1, 8'h15, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1 check_cleared("mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 8'h00, 1'b0, 1'b1);
    chk("restart_code", out_code, 10'b0011111010);
    chk("restart_rd", rd_out, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/enc8b10b_ctrl.md
ENC8B10B_CTRL -- requirements
Module: enc8b10b_ctrl

Interface
REQ-001 The block SHALL have parameter N_SYNC, default 4, giving the number of K28.5 commas emitted after reset before data is accepted (range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the upstream byte is valid.
REQ-005 The block SHALL have port in_data, input, 8, the byte HGFEDCBA, where x = in_data[4:0] and y = in_data[7:5].
REQ-006 The block SHALL have port in_k, input, 1, meaning in_data is a control (K) symbol.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_code holds a symbol.
REQ-009 The block SHALL have port out_code, output, 10, the symbol {a,b,c,d,e,i,f,g,h,j}; bit 9 (a) is transmitted first.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the downstream consumes out_code this cycle.
REQ-011 The block SHALL have port rd_out, output, 1, the running disparity after the symbol on out_code (0 = RD-, 1 = RD+).
REQ-012 The block SHALL have port sync_done, output, 1, high while in state DATA.
REQ-013 The block SHALL have port err_k, output, 1, a flag for an illegal K code, valid with out_code.

Function
REQ-014 Load condition: load = !out_valid | out_ready; out_code, rd_out and err_k SHALL change only on a clock edge where load=1.
REQ-015 While out_valid=1 and out_ready=0, out_code, rd_out and err_k SHALL hold stable.
REQ-016 The FSM SHALL have states SYNC and DATA; reset SHALL enter SYNC with the comma counter set to N_SYNC.
REQ-017 In SYNC: in_ready=0; each load SHALL emit K28.5 and decrement the counter; the load that emits the N_SYNC-th comma SHALL transition to DATA.
REQ-018 In DATA: in_ready = load; if in_valid&in_ready then the input SHALL be encoded, otherwise K28.5 (idle) SHALL be emitted.
REQ-019 Latency: a byte accepted on edge N SHALL appear on out_code after edge N, i.e. a 1-cycle registered output with no bubbles under continuous out_ready=1.
REQ-020 Encoding SHALL follow the IEEE 802.3 Clause 36 5b/6b and 3b/4b tables using the current RD.
  - 5b/6b SHALL use the RD at symbol start.
  - 3b/4b SHALL use the RD after the 6b sub-block.
REQ-021 The D.x.A7 alternate (0111 for RD-, 1000 for RD+) SHALL be used when RD- and x∈{17,18,20}, or RD+ and x∈{11,13,14}; otherwise D.x.P7 SHALL be used.
REQ-022 Legal K codes are K28.0–K28.7, K23.7, K27.7, K29.7 and K30.7; K28.y SHALL use the K column of the 3b/4b table.
REQ-023 An illegal K (in_k=1, code not legal) SHALL be accepted, replaced by K28.5, and flagged with err_k=1 for that symbol only.
REQ-024 RD update: a sub-block of disparity ±2 SHALL flip RD, and a balanced sub-block SHALL keep RD; rd_out SHALL register the final RD at load.
REQ-025 A 6b 000111/111000 and a 4b 0011/1100 SHALL be treated as neutral.
REQ-026 in_data and in_k SHALL be ignored when in_valid=0 or in_ready=0.
REQ-027 No symbol SHALL be dropped or duplicated: each in_valid&in_ready handshake SHALL produce exactly one encoded out_code.

Reset
REQ-028 On rst_n=0, asynchronously: out_valid=0, out_code=10'b0, rd_out=0 (RD-), err_k=0, sync_done=0, in_ready=0, state=SYNC, counter=N_SYNC.
REQ-029 The first edge after rst_n deasserts SHALL load K28.5 RD- (0011111010) with out_valid=1.
REQ-030 Reset asserted mid-stream SHALL discard the in-flight symbol; the block SHALL restart SYNC at RD-.

Verification
REQ-031 Reset release with out_ready=1 and N_SYNC=4 -> out_code = 0011111010, 1100000101, 0011111010, 1100000101; sync_done=1 after the 4th; in_ready rises on the 4th load.
REQ-032 Accept D0.0 (in_data=8'h00, in_k=0) at RD- -> out_code=1001110100, rd_out=0; then D21.5 (8'hB5) -> 1010101010, rd_out=0.
REQ-033 Accept D17.7 (8'hF1) at RD- -> A7 used, out_code=1000110111; back-to-back bytes with out_ready=1 -> one symbol per cycle, no idles inserted.
REQ-034 out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_code/rd_out held; on out_ready=1 the pending byte is encoded with correct RD.
REQ-035 Illegal K (in_k=1, in_data=8'h00) -> K28.5 emitted for current RD, err_k=1 one symbol; legal K28.5 (8'hBC) -> err_k=0.
REQ-036 rst_n pulsed low while in DATA -> outputs cleared immediately; SYNC commas restart at 0011111010.
